// File: rtl/psu_fan_health_pkg.sv
// Shared encodings for the PSU fan health qualifier: states, LED codes,
// SwCtrl and FanStatus bit positions.
package psu_fan_health_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_OK      = 3'd1,
        ST_SUSPECT = 3'd2,
        ST_FAULT   = 3'd3,
        ST_RECOVER = 3'd4
    } fan_state_t;

    localparam logic [1:0] LED_OFF   = 2'b11;
    localparam logic [1:0] LED_RED   = 2'b10;
    localparam logic [1:0] LED_GREEN = 2'b01;

    localparam int unsigned SW_LED_CTRL  = 0;
    localparam int unsigned SW_LED_OFF   = 1;
    localparam int unsigned SW_LED_RED   = 2;
    localparam int unsigned SW_LATCH_CLR = 7;

    localparam int unsigned FS_LATCH      = 7;
    localparam int unsigned FS_STATE_LSB  = 4;
    localparam int unsigned FS_TACH_HIGH  = 3;
    localparam int unsigned FS_TACH_LOW   = 2;
    localparam int unsigned FS_PSU_GOOD   = 1;
    localparam int unsigned FS_FAN_FAULT  = 0;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned BLINK_W = 14;

    // Second counter saturates rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/psu_led_mux.sv
// Registered PSU LED: hardware code from the FSM state and blink phase,
// optionally overridden by software control bits.
module psu_led_mux
    import psu_fan_health_pkg::*;
(
    input  logic       CLKi,
    input  logic       ResetNi,
    input  fan_state_t state,
    input  logic       blink,
    input  logic [2:0] sw_ctrl,
    output logic [1:0] led
);

    logic [1:0] hw_led;
    logic [1:0] led_next;

    always_comb begin
        hw_led = LED_OFF;
        unique case (state)
            ST_INIT:              hw_led = LED_OFF;
            ST_OK, ST_SUSPECT:    hw_led = LED_GREEN;
            ST_FAULT:             hw_led = LED_RED;
            ST_RECOVER:           hw_led = blink ? LED_RED : LED_OFF;
            default:              hw_led = LED_OFF;
        endcase
    end

    always_comb begin
        led_next = hw_led;
        if (sw_ctrl[SW_LED_CTRL]) begin
            if (sw_ctrl[SW_LED_OFF])
                led_next = LED_OFF;
            else
                led_next = sw_ctrl[SW_LED_RED] ? LED_RED : LED_GREEN;
        end
    end

    always_ff @(posedge CLKi or negedge ResetNi) begin
        if (!ResetNi)
            led <= LED_OFF;
        else
            led <= led_next;
    end

endmodule

// File: rtl/psu_fan_health.sv
// Per-second fan/PSU health qualifier: debounce FSM, fault latch,
// interrupt pulse, status byte and LED drive.
module psu_fan_health
    import psu_fan_health_pkg::*;
#(
    parameter int FAULT_SECS = 3,
    parameter int CLEAR_SECS = 5,
    parameter int BLINK_BIT  = 13
) (
    input  logic       CLKi,
    input  logic       ResetNi,
    input  logic       SecTick,
    input  logic       TachLow,
    input  logic       TachHigh,
    input  logic       PsuGood,
    input  logic [7:0] SwCtrl,
    output logic [1:0] PsuLed,
    output logic       FanFault,
    output logic       FaultIrq,
    output logic [7:0] FanStatus
);

    localparam logic [CNT_W-1:0] FAULT_N = 4'(FAULT_SECS);
    localparam logic [CNT_W-1:0] CLEAR_N = 4'(CLEAR_SECS);

    fan_state_t         state, next_state;
    logic [CNT_W-1:0]   cnt, next_cnt, cnt_inc;
    logic [BLINK_W-1:0] blink;
    logic               s_low, s_high, s_good;
    logic               latch, sw7_prev;
    logic               bad, fault_entry, irq_set, clr_req, in_fault_now;
    logic               unused_sw;

    assign unused_sw    = ^SwCtrl[6:3];
    assign bad          = TachLow | TachHigh | ~PsuGood;
    assign cnt_inc      = sat_inc(cnt);
    assign in_fault_now = (state == ST_FAULT) || (state == ST_RECOVER);

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        if (SecTick) begin
            unique case (state)
                ST_INIT: begin
                    next_state = ST_OK;
                    next_cnt   = '0;
                end
                ST_OK: begin
                    if (bad) begin
                        if (FAULT_N == 4'd1) begin
                            next_state = ST_FAULT;
                            next_cnt   = '0;
                        end else begin
                            next_state = ST_SUSPECT;
                            next_cnt   = 4'd1;
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (!bad) begin
                        next_state = ST_OK;
                        next_cnt   = '0;
                    end else if (cnt_inc == FAULT_N) begin
                        next_state = ST_FAULT;
                        next_cnt   = '0;
                    end else begin
                        next_cnt   = cnt_inc;
                    end
                end
                ST_FAULT: begin
                    next_cnt = '0;
                    if (!bad) begin
                        if (CLEAR_N == 4'd1) begin
                            next_state = ST_OK;
                        end else begin
                            next_state = ST_RECOVER;
                            next_cnt   = 4'd1;
                        end
                    end
                end
                ST_RECOVER: begin
                    if (bad) begin
                        next_state = ST_FAULT;
                        next_cnt   = '0;
                    end else if (cnt_inc == CLEAR_N) begin
                        next_state = ST_OK;
                        next_cnt   = '0;
                    end else begin
                        next_cnt   = cnt_inc;
                    end
                end
                default: begin
                    next_state = ST_INIT;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    // Latch set on any entry to FAULT; the IRQ only on a fresh fault.
    assign fault_entry = (next_state == ST_FAULT) && (state != ST_FAULT);
    assign irq_set     = fault_entry && ((state == ST_OK) || (state == ST_SUSPECT));
    assign clr_req     = SwCtrl[SW_LATCH_CLR] && !sw7_prev && !in_fault_now;

    always_ff @(posedge CLKi or negedge ResetNi) begin
        if (!ResetNi) begin
            state    <= ST_INIT;
            cnt      <= '0;
            blink    <= '0;
            s_low    <= 1'b0;
            s_high   <= 1'b0;
            s_good   <= 1'b0;
            FanFault <= 1'b0;
            FaultIrq <= 1'b0;
            latch    <= 1'b0;
            sw7_prev <= 1'b0;
        end else begin
            state    <= next_state;
            cnt      <= next_cnt;
            blink    <= blink + 1'b1;
            FanFault <= (next_state == ST_FAULT) || (next_state == ST_RECOVER);
            FaultIrq <= irq_set;
            latch    <= fault_entry | (latch & ~clr_req);
            sw7_prev <= SwCtrl[SW_LATCH_CLR];
            if (SecTick) begin
                s_low  <= TachLow;
                s_high <= TachHigh;
                s_good <= PsuGood;
            end
        end
    end

    always_comb begin
        FanStatus                              = '0;
        FanStatus[FS_LATCH]                    = latch;
        FanStatus[FS_STATE_LSB +: 3]           = state;
        FanStatus[FS_TACH_HIGH]                = s_high;
        FanStatus[FS_TACH_LOW]                 = s_low;
        FanStatus[FS_PSU_GOOD]                 = s_good;
        FanStatus[FS_FAN_FAULT]                = FanFault;
    end

    // LED is driven from next_state so it shares the one-cycle latency.
    psu_led_mux u_led (
        .CLKi    (CLKi),
        .ResetNi (ResetNi),
        .state   (next_state),
        .blink   (blink[BLINK_BIT]),
        .sw_ctrl (SwCtrl[2:0]),
        .led     (PsuLed)
    );

endmodule
